// File: rtl/mdu_seq_pkg.sv
// Shared encodings for the multiply/divide unit: op select, sequencer states
// and the SPECIAL funct codes CTRL decodes into MDU requests.
package mdu_seq_pkg;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  // op[0]=0 selects the signed variant, op[1]=1 selects divide
  function automatic logic mdu_is_signed(input logic [1:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/mdu_signfix.sv
// Combinational sign correction applied to the raw unsigned result in FIX.
// Sign flags are already zero for unsigned ops, so no op-signedness input is needed.
module mdu_signfix #(
  parameter int W = 32
) (
  input  logic           is_div,
  input  logic           sa,
  input  logic           sb,
  input  logic [2*W-1:0] prod,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo
);

  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   q_fix;
  logic [W-1:0]   r_fix;

  always_comb begin
    prod_fix = (sa ^ sb) ? -prod : prod;
    q_fix    = (sa ^ sb) ? -prod[W-1:0] : prod[W-1:0];
    // truncating division: remainder follows the dividend's sign
    r_fix    = sa ? -prod[2*W-1:W] : prod[2*W-1:W];
    hi       = is_div ? r_fix : prod_fix[2*W-1:W];
    lo       = is_div ? q_fix : prod_fix[W-1:0];
  end

endmodule

// File: rtl/mdu_seq.sv
// Bit-serial MULT/MULTU/DIV/DIVU sequencer owning HI/LO; result lands WIDTH+2 edges after start.
// MDU_EARLY_OUT_EN: multiplies finish as soon as the remaining multiplier bits are zero.
module mdu_seq
  import mdu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdu_state_e         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
`ifdef MDU_EARLY_OUT_EN
  logic [CW-1:0]      align_sh;
`endif

  assign a_neg = mdu_is_signed(op) & a[WIDTH-1];
  assign b_neg = mdu_is_signed(op) & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // multiply: prod shifts right, partial sum enters at the top
  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (b_q[0] ? a_q : '0)};
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  // divide: prod = {remainder, dividend/quotient}, shifting left
  assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};
`ifdef MDU_EARLY_OUT_EN
  assign align_sh  = CW'(WIDTH - 1) - cnt_q;
`endif

  mdu_signfix #(.W(WIDTH)) u_signfix (
    .is_div (op_q[1]),
    .sa     (sa_q),
    .sb     (sb_q),
    .prod   (prod_q),
    .hi     (fix_hi),
    .lo     (fix_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      MDU_IDLE: begin
        if (start) begin
          state_d = MDU_CALC;
          cnt_d   = '0;
          op_d    = op;
          sa_d    = a_neg;
          sb_d    = b_neg;
          a_d     = a_mag;
          b_d     = b_mag;
          prod_d  = op[1] ? {{WIDTH{1'b0}}, a_mag} : '0;
          busy_d  = 1'b1;
        end else begin
          if (wr_hi) hi_d = wd;
          if (wr_lo) lo_d = wd;
        end
      end
      MDU_CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) begin
          if (!div_diff[WIDTH]) prod_d = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
          else                  prod_d = {div_shift[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
        end else begin
          prod_d = mul_next;
          b_d    = b_q >> 1;
        end
        if (cnt_q == CW'(WIDTH - 1)) state_d = MDU_FIX;
`ifdef MDU_EARLY_OUT_EN
        if (!op_q[1] && (b_q >> 1) == '0) begin
          prod_d  = mul_next >> align_sh;
          state_d = MDU_FIX;
        end
`endif
      end
      MDU_FIX: begin
        state_d = MDU_IDLE;
        hi_d    = fix_hi;
        lo_d    = fix_lo;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: results, latency, done pulse, HI/LO writes and aborts.
module tb_mdu_seq;
  import mdu_seq_pkg::*;

`ifdef MDU_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b, wd;
  logic        wr_hi, wr_lo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_err    = 0;

  mdu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // inject: 0 none, 1 wr_lo while busy, 2 second start while busy
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int inject);
    logic [31:0] h0, l0;
    int n, bc;
    h0 = hi;
    l0 = lo;
    start = 1'b1; op = o; a = av; b = bv;
    step();
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    a = 32'h13579bdf; b = 32'h2468ace0; op = ~o;
    chk({tag, " busy_after_accept"}, busy, 1);
    chk({tag, " hi_held"}, hi, h0);
    chk({tag, " lo_held"}, lo, l0);
    n = 1;
    bc = 0;
    while (done !== 1'b1 && n < 60) begin
      if (busy === 1'b1) bc++;
      if (n == 5 && inject == 1) begin
        wr_lo = 1'b1; wd = 32'hffff0000;
      end else if (n == 5 && inject == 2) begin
        start = 1'b1; op = MDU_MULTU; a = 32'd2; b = 32'd2;
      end else begin
        wr_lo = 1'b0; start = 1'b0;
      end
      step();
      n++;
    end
    wr_lo = 1'b0; start = 1'b0;
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " busy_cycles"}, bc, exp_lat - 1);
    chk({tag, " hi"}, hi, exp_hi);
    chk({tag, " lo"}, lo, exp_lo);
    chk({tag, " busy_clear"}, busy, 0);
    step();
    chk({tag, " done_one_cycle"}, done, 0);
    chk({tag, " hi_hold"}, hi, exp_hi);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wd = '0;
    #12;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    rst = 1'b1;
    step();

    run_op("multu_max", MDU_MULTU, 32'hffffffff, 32'hffffffff, 34, 32'hfffffffe, 32'h00000001, 0);
    run_op("mult_neg", MDU_MULT, 32'hfffffffd, 32'd7, EO ? 5 : 34, 32'hffffffff, 32'hffffffeb, 0);
    run_op("div_neg", MDU_DIV, 32'hfffffff9, 32'd2, 34, 32'hffffffff, 32'hfffffffd, 0);
    run_op("divu_zero", MDU_DIVU, 32'd100, 32'd0, 34, 32'd100, 32'hffffffff, 0);
    run_op("div_zero_neg", MDU_DIV, 32'hfffffffb, 32'd0, 34, 32'hfffffffb, 32'h00000001, 0);
    run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hffffffff, 34, 32'h00000000, 32'h80000000, 0);

    wr_hi = 1'b1; wd = 32'h12345678;
    step();
    wr_hi = 1'b0;
    chk("mthi hi", hi, 32'h12345678);
    chk("mthi lo_untouched", lo, 32'h80000000);
    wr_lo = 1'b1; wd = 32'h9abcdef0;
    step();
    wr_lo = 1'b0;
    chk("mtlo lo", lo, 32'h9abcdef0);
    chk("mtlo hi_untouched", hi, 32'h12345678);
    wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'ha5a5a5a5;
    step();
    chk("mthilo hi", hi, 32'ha5a5a5a5);
    chk("mthilo lo", lo, 32'ha5a5a5a5);

    // start wins over a same-edge write: hi/lo must still read a5a5a5a5 after accept
    wr_hi = 1'b1; wr_lo = 1'b1; wd = 32'hdeadbeef;
    run_op("start_vs_wr", MDU_MULTU, 32'd3, 32'd4, EO ? 5 : 34, 32'h0, 32'd12, 0);

    run_op("wr_lo_busy", MDU_MULT, 32'd3, 32'h00010000, EO ? 19 : 34, 32'h0, 32'h00030000, 1);
    run_op("start_busy", MDU_DIVU, 32'd1000, 32'd7, 34, 32'd6, 32'd142, 2);

    start = 1'b1; op = MDU_DIVU; a = 32'd1000; b = 32'd3;
    step();
    start = 1'b0;
    repeat (10) step();
    chk("pre_abort busy", busy, 1);
    rst = 1'b0;
    #2;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort hi", hi, 0);
    chk("abort lo", lo, 0);
    #2;
    rst = 1'b1;
    step();
    run_op("after_abort", MDU_MULTU, 32'd5, 32'd1, EO ? 3 : 34, 32'h0, 32'd5, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair of the multi-cycle MIPS core.
- Takes MULT/MULTU/DIV/DIVU requests from the main control FSM with a start/busy handshake.
- Computes one bit per cycle and returns results on hi/lo.
- Services MTHI/MTLO writes when idle.
- CTRL stalls MFHI/MFLO and further MDU ops while busy=1.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported for the core; the counter width is derived as clog2(WIDTH)+1.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: asynchronous, active-low
- start  in  1  request a new operation; sampled on a clk edge
- op  in  2  operation select: MULT, MULTU, DIV, DIVU
- a  in  WIDTH  rs operand (multiplicand / dividend)
- b  in  WIDTH  rt operand (multiplier / divisor)
- wr_hi  in  1  MTHI write strobe
- wr_lo  in  1  MTLO write strobe
- wd  in  WIDTH  MTHI/MTLO write data
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when hi/lo take a new result
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (rst=0, async): state=IDLE; busy=0, done=0, hi=0, lo=0, counter=0, internal operand regs=0.
- States and transitions:
  - IDLE -> CALC on start.
  - CALC -> FIX when the counter reaches WIDTH.
  - FIX -> IDLE unconditionally.
- Accept: on an edge with state=IDLE and start=1, latch op, |a| and |b|, and the sign bits. Signed ops take magnitudes; unsigned ops take values as-is. The counter clears and busy=1 from the next cycle.
- CALC, multiply: one shift-add step per cycle into a 2*WIDTH product register.
- CALC, divide: one restoring shift-subtract step per cycle, giving quotient and remainder.
- Counter: increments each CALC cycle; after exactly WIDTH CALC cycles, go to FIX.
- FIX: apply sign correction, write hi/lo, drop busy, pulse done.
  - Results are visible 1+WIDTH+1 = 34 edges after the accepting edge for WIDTH=32.
  - done=1 for exactly the first cycle hi/lo hold the new value.
- Result mapping:
  - Multiply: {hi,lo} = 64-bit product. Signed product is negated iff sign(a)^sign(b).
  - Divide: lo = quotient, hi = remainder.
  - Signed quotient sign = sa^sb; remainder sign = sa (truncating division, MIPS semantics).
- Divide by zero: no trap. Unsigned: lo=0xFFFFFFFF, hi=a.
  - Signed: lo=0x00000001 if a<0 else 0xFFFFFFFF; hi=a. This is the raw restoring result followed by sign fix.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy: ignored; no queueing.
- wr_hi/wr_lo in IDLE: the register updates from wd on the next edge. Both may be asserted together.
- wr_hi/wr_lo while busy: ignored.
- start and wr_* on the same IDLE edge: start has priority and the write is dropped.
- op/a/b changes after acceptance have no effect.
- Reset mid-operation aborts immediately; all outputs return to reset values.
- hi/lo hold their value between operations. They are never modified during CALC.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: during a multiply, when the remaining unprocessed multiplier bits are all zero, shift the partial product into final alignment and go to FIX on the next edge. Latency becomes 2 + (index of highest set bit of |b|) + 1. A zero multiplier takes 2 edges through CALC->FIX. Results are identical to the fixed-latency path. Divide is unaffected.
- Undefined: fixed latency of WIDTH+2 edges for all ops.

Decomposition:
- Shared def header/package holds:
  - Op encodings: MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11.
  - State encodings: MDU_IDLE, MDU_CALC, MDU_FIX.
  - The MDU funct codes used by CTRL.
- One sub-module is natural: mdu_signfix. It is combinational negate/sign correction for the product, quotient and remainder, and is reused in FIX.
- The FSM, counter and datapath registers stay in mdu_seq.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> after 34 edges hi=0xFFFFFFFE lo=0x00000001, done pulse 1 cycle, busy high for 33 cycles.
- MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. Then DIV a=-7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF hi=100. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- IDLE wr_hi=1 wd=0x12345678, then wr_lo with 0x9ABCDEF0 -> hi/lo updated next edge. A wr_lo during a busy MULT is ignored and the final lo is the product.
- Second start 5 cycles into a DIVU is ignored (result matches the first op only). rst pulsed low at cycle 10 of CALC -> busy=0, hi=lo=0 asynchronously, next start runs normally.
- With MDU_EARLY_OUT_EN: MULTU a=5 b=1 -> lo=5 hi=0 after 3 edges. Without the macro -> 34 edges, same result.
